// File: rtl/fmm_df_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fmm_df_sync_ctrl
//
// Sequences start, ready, done and continue for the fmm_reduce_kernel dataflow
// region (entry_proc, Block_entry_proc_1, Block_entry_proc).
//   - The region ap_start is fanned out to NPROC processes.
//   - Sticky per-process ready and done bits let the region report ready or
//     done only once every process has handshaked.
//   - The number of iterations in flight is limited to MAX_INFLIGHT.
//
// Optional feature: define DL_WATCHDOG_EN to build a stall watchdog.
//   - The watchdog counts cycles with work in flight and no ready or done
//     activity.
//   - When the count reaches WD_LIMIT, stall_flag is set and stall_mask records
//     the processes that have not finished.
//   - Without the macro, stall_flag and stall_mask are tied to 0.
//
// Ports
//   dl_clock      in   clock, every register on the rising edge
//   dl_reset      in   asynchronous reset, active low
//   ap_start      in   region start request (a level, held until ap_ready)
//   ap_ready      out  region accepted one iteration (1-cycle pulse)
//   ap_done       out  all processes done for the oldest iteration
//   ap_continue   in   downstream accepts ap_done
//   ap_idle       out  region idle
//   proc_start    out  per-process ap_start                  [NPROC]
//   proc_ready    in   per-process ap_ready                  [NPROC]
//   proc_done     in   per-process ap_done                   [NPROC]
//   proc_idle     in   per-process ap_idle                   [NPROC]
//   proc_continue out  per-process ap_continue               [NPROC]
//   inflight      out  iterations started but not yet retired [3]
//   stall_flag    out  watchdog tripped
//   stall_mask    out  processes not yet done at trip time   [NPROC]
// -----------------------------------------------------------------------------
module fmm_df_sync_ctrl #(
    parameter int NPROC        = 3,
    parameter int MAX_INFLIGHT = 2,
    parameter int WD_W         = 16,
    parameter int WD_LIMIT     = 4096
) (
    input  logic             dl_clock,
    input  logic             dl_reset,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    input  logic             ap_continue,
    output logic             ap_idle,
    output logic [NPROC-1:0] proc_start,
    input  logic [NPROC-1:0] proc_ready,
    input  logic [NPROC-1:0] proc_done,
    input  logic [NPROC-1:0] proc_idle,
    output logic [NPROC-1:0] proc_continue,
    output logic [2:0]       inflight,
    output logic             stall_flag,
    output logic [NPROC-1:0] stall_mask
);

    localparam logic [2:0] MAX_INF = 3'(MAX_INFLIGHT);

    // Reject parameter values that the 3-bit inflight counter or the watchdog
    // counter cannot represent.
    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 7) begin : g_bad_max_inflight
        $error("fmm_df_sync_ctrl: MAX_INFLIGHT must be 1..7");
    end
    if (WD_LIMIT < 1 || WD_LIMIT >= (1 << WD_W)) begin : g_bad_wd_limit
        $error("fmm_df_sync_ctrl: WD_LIMIT must be 1..2**WD_W-1");
    end

    logic [NPROC-1:0] rdy_q, rdy_d;
    logic [NPROC-1:0] done_q, done_d;
    logic [2:0]       inflight_q, inflight_d;

    logic             can_start;
    logic [NPROC-1:0] rdy_hit;
    logic             retire;

    always_comb begin
        can_start     = ap_start & (inflight_q != MAX_INF);
        // A process that has already readied this iteration is not restarted.
        proc_start    = {NPROC{can_start}} & ~rdy_q;
        rdy_hit       = proc_ready & proc_start;
        ap_ready      = can_start & (&(rdy_q | rdy_hit));

        ap_done       = (&(done_q | proc_done)) & (inflight_q != 3'd0);
        retire        = ap_done & ap_continue;
        proc_continue = {NPROC{retire}};

        ap_idle       = (inflight_q == 3'd0) & (&proc_idle) & ~ap_start;
        inflight      = inflight_q;

        rdy_d  = ap_ready ? '0 : (rdy_q | rdy_hit);
        // Stray done pulses are captured even with nothing in flight.
        done_d = retire ? '0 : (done_q | proc_done);

        // An accept and a retire in the same cycle cancel each other out.
        inflight_d = inflight_q;
        if (ap_ready && !retire) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!ap_ready && retire) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            rdy_q      <= '0;
            done_q     <= '0;
            inflight_q <= 3'd0;
        end else begin
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef DL_WATCHDOG_EN
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_LIMIT);

    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             stall_flag_q, stall_flag_d;
    logic [NPROC-1:0] stall_mask_q, stall_mask_d;
    logic             progress;

    always_comb begin
        progress     = |(proc_ready | proc_done);
        wd_cnt_d     = wd_cnt_q;
        stall_flag_d = stall_flag_q;
        stall_mask_d = stall_mask_q;

        if (retire || progress) begin
            wd_cnt_d = '0;
        end else if (inflight_q != 3'd0 && wd_cnt_q != WD_LIM) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        // The flag and mask stay set until the stuck iteration finally retires.
        if (retire) begin
            stall_flag_d = 1'b0;
            stall_mask_d = '0;
        end else if (!stall_flag_q && wd_cnt_d == WD_LIM) begin
            stall_flag_d = 1'b1;
            stall_mask_d = ~(done_q | proc_done);
        end
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            wd_cnt_q     <= '0;
            stall_flag_q <= 1'b0;
            stall_mask_q <= '0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            stall_flag_q <= stall_flag_d;
            stall_mask_q <= stall_mask_d;
        end
    end

    assign stall_flag = stall_flag_q;
    assign stall_mask = stall_mask_q;
`else
    assign stall_flag = 1'b0;
    assign stall_mask = '0;
`endif

endmodule

// File: tb/tb_fmm_df_sync_ctrl.sv
module tb_fmm_df_sync_ctrl;

    localparam int NPROC = 3;
    localparam int MAXI  = 2;
    localparam int WDL   = 16;

    logic       dl_clock    = 1'b0;
    logic       dl_reset    = 1'b0;
    logic       ap_start    = 1'b0;
    logic       ap_continue = 1'b0;
    logic [2:0] proc_ready  = 3'b000;
    logic [2:0] proc_done   = 3'b000;
    logic [2:0] proc_idle   = 3'b111;

    wire        ap_ready;
    wire        ap_done;
    wire        ap_idle;
    wire        stall_flag;
    wire [2:0]  proc_start;
    wire [2:0]  proc_continue;
    wire [2:0]  inflight;
    wire [2:0]  stall_mask;

    int errors = 0;
    int checks = 0;

    fmm_df_sync_ctrl #(
        .NPROC(NPROC), .MAX_INFLIGHT(MAXI), .WD_W(16), .WD_LIMIT(WDL)
    ) dut (
        .dl_clock(dl_clock), .dl_reset(dl_reset), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .ap_idle(ap_idle), .proc_start(proc_start), .proc_ready(proc_ready),
        .proc_done(proc_done), .proc_idle(proc_idle),
        .proc_continue(proc_continue), .inflight(inflight),
        .stall_flag(stall_flag), .stall_mask(stall_mask)
    );

    always #5 dl_clock = ~dl_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the region ----------------
    bit       m_rdy  [NPROC];
    bit       m_done [NPROC];
    int       m_infl;
    int       m_quiet;
    bit       m_flag;
    bit [2:0] m_mask;

    always @(negedge dl_clock) begin
        bit       room, all_r, all_d, e_ready, e_done, e_retire, e_idle;
        bit [2:0] e_ps;
        if (!dl_reset) begin
            for (int i = 0; i < NPROC; i++) begin
                m_rdy[i]  = 1'b0;
                m_done[i] = 1'b0;
            end
            m_infl  = 0;
            m_quiet = 0;
            m_flag  = 1'b0;
            m_mask  = 3'b000;
            chk("rst_ap_ready", 32'(ap_ready), 32'd0);
            chk("rst_ap_done", 32'(ap_done), 32'd0);
            chk("rst_inflight", 32'(inflight), 32'd0);
            chk("rst_proc_cont", 32'(proc_continue), 32'd0);
            chk("rst_stall", 32'(stall_flag), 32'd0);
            chk("rst_ap_idle", 32'(ap_idle), 32'((proc_idle == 3'b111) && !ap_start));
        end else begin
            room  = (m_infl < MAXI);
            all_r = 1'b1;
            all_d = 1'b1;
            for (int i = 0; i < NPROC; i++) begin
                e_ps[i] = ap_start && room && !m_rdy[i];
                if (!(m_rdy[i] || (proc_ready[i] && e_ps[i]))) all_r = 1'b0;
                if (!(m_done[i] || proc_done[i])) all_d = 1'b0;
            end
            e_ready  = ap_start && room && all_r;
            e_done   = all_d && (m_infl > 0);
            e_retire = e_done && ap_continue;
            e_idle   = (m_infl == 0) && (proc_idle == 3'b111) && !ap_start;

            chk("ap_ready", 32'(ap_ready), 32'(e_ready));
            chk("ap_done", 32'(ap_done), 32'(e_done));
            chk("ap_idle", 32'(ap_idle), 32'(e_idle));
            chk("proc_start", 32'(proc_start), 32'(e_ps));
            chk("proc_continue", 32'(proc_continue), 32'(e_retire ? 3'b111 : 3'b000));
            chk("inflight", 32'(inflight), 32'(m_infl));
            chk("stall_flag", 32'(stall_flag), 32'(m_flag));
            chk("stall_mask", 32'(stall_mask), 32'(m_mask));

`ifdef DL_WATCHDOG_EN
            if (e_retire || (proc_ready != 3'b000) || (proc_done != 3'b000)) m_quiet = 0;
            else if (m_infl > 0 && m_quiet < WDL) m_quiet++;
            if (e_retire) begin
                m_flag = 1'b0;
                m_mask = 3'b000;
            end else if (!m_flag && m_quiet == WDL) begin
                m_flag = 1'b1;
                for (int i = 0; i < NPROC; i++) m_mask[i] = !(m_done[i] || proc_done[i]);
            end
`endif
            for (int i = 0; i < NPROC; i++) begin
                m_rdy[i]  = e_ready  ? 1'b0 : (m_rdy[i] || (proc_ready[i] && e_ps[i]));
                m_done[i] = e_retire ? 1'b0 : (m_done[i] || proc_done[i]);
            end
            m_infl = m_infl + int'(e_ready) - int'(e_retire);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge dl_clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        #1 chk("init_idle", 32'(ap_idle), 32'd1);
        dl_reset = 1'b1;

        // T1: staggered readies, ap_ready on the last one
        step();
        ap_start = 1'b1; proc_idle = 3'b000;
        proc_ready = 3'b001;
        #1 chk("t1_ps0", 32'(proc_start), 32'b111);
        chk("t1_rdy0", 32'(ap_ready), 32'd0);
        step();
        proc_ready = 3'b100;
        #1 chk("t1_ps1", 32'(proc_start), 32'b110);
        chk("t1_rdy1", 32'(ap_ready), 32'd0);
        step();
        proc_ready = 3'b010;
        #1 chk("t1_ps2", 32'(proc_start), 32'b010);
        chk("t1_rdy2", 32'(ap_ready), 32'd1);
        step();
        proc_ready = 3'b000;
        #1 chk("t1_infl", 32'(inflight), 32'd1);
        $display("T1 staggered ready done: inflight=%0d", inflight);

        // T2: all ready at once, T3: limit reached
        proc_ready = 3'b111;
        #1 chk("t2_rdy", 32'(ap_ready), 32'd1);
        step();
        proc_ready = 3'b000;
        #1 chk("t3_ps", 32'(proc_start), 32'b000);
        chk("t3_rdy", 32'(ap_ready), 32'd0);
        chk("t3_infl", 32'(inflight), 32'd2);
        step();
        chk("t3_ps_hold", 32'(proc_start), 32'b000);
        proc_done = 3'b111; ap_continue = 1'b1;
        #1 chk("t3_done", 32'(ap_done), 32'd1);
        chk("t3_cont", 32'(proc_continue), 32'b111);
        step();
        proc_done = 3'b000; ap_continue = 1'b0;
        #1 chk("t3_infl1", 32'(inflight), 32'd1);
        chk("t3_resume", 32'(proc_start), 32'b111);
        $display("T2/T3 limit and resume done: inflight=%0d", inflight);

        // T4: partial done, held done, retire with simultaneous ready
        proc_done = 3'b011;
        #1 chk("t4_nodone", 32'(ap_done), 32'd0);
        step();
        proc_done = 3'b000;
        #1 chk("t4_nodone2", 32'(ap_done), 32'd0);
        step();
        proc_done = 3'b100;
        #1 chk("t4_done", 32'(ap_done), 32'd1);
        chk("t4_nocont", 32'(proc_continue), 32'b000);
        step();
        chk("t4_held", 32'(ap_done), 32'd1);
        proc_ready = 3'b111; ap_continue = 1'b1;
        #1 chk("t4_both_rdy", 32'(ap_ready), 32'd1);
        chk("t4_both_cont", 32'(proc_continue), 32'b111);
        step();
        proc_ready = 3'b000; proc_done = 3'b000; ap_continue = 1'b0; ap_start = 1'b0;
        #1 chk("t4_infl", 32'(inflight), 32'd1);
        chk("t4_cleared", 32'(ap_done), 32'd0);
        $display("T4 done sync done: inflight=%0d", inflight);

        // T5: watchdog
        proc_done = 3'b001;
        step();
        proc_done = 3'b000;
        repeat (15) step();
        chk("t5_pre", 32'(stall_flag), 32'd0);
        step();
`ifdef DL_WATCHDOG_EN
        chk("t5_flag", 32'(stall_flag), 32'd1);
        chk("t5_mask", 32'(stall_mask), 32'b110);
`else
        chk("t5_flag", 32'(stall_flag), 32'd0);
`endif
        repeat (3) step();
        proc_done = 3'b110; ap_continue = 1'b1;
        step();
        proc_done = 3'b000; ap_continue = 1'b0;
        #1 chk("t5_clear", 32'(stall_flag), 32'd0);
        chk("t5_infl", 32'(inflight), 32'd0);
        $display("T5 watchdog done: stall_flag=%0b", stall_flag);

        // T6: asynchronous reset mid-iteration
        ap_start = 1'b1; proc_ready = 3'b111;
        step();
        proc_ready = 3'b101;
        step();
        proc_ready = 3'b000;
        #1 chk("t6_ps", 32'(proc_start), 32'b010);
        chk("t6_infl", 32'(inflight), 32'd1);
        ap_start = 1'b0; proc_idle = 3'b111;
        #1 dl_reset = 1'b0;
        #1 chk("t6_infl0", 32'(inflight), 32'd0);
        chk("t6_idle", 32'(ap_idle), 32'd1);
        step();
        step();
        dl_reset = 1'b1;
        ap_start = 1'b1;
        #1 chk("t6_restart", 32'(proc_start), 32'b111);
        step();
        ap_start = 1'b0;
        repeat (2) step();
        $display("T6 reset mid-iteration done: inflight=%0d", inflight);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
